fetch_queue: RTL and testbench

Decoupled instruction-fetch front end. It generates sequential PCs, issues them to a latency-tolerant instruction memory over a valid/ready request plus in-order response interface, and buffers returned words with their PCs. It presents them to the IF/ID pipeline register under a valid/ready handshake. It replaces the combinational PC register and instruction-memory path upstream of decode, and handles Execute-stage redirects (taken branch, jal, jalr) by flushing the queue and discarding stale in-flight responses.

---
 rtl/riscv_fetch_pkg.sv | 18 +
 rtl/fetch_slot_array.sv | 49 ++++
 rtl/fetch_queue.sv | 134 +++++++++++++
 tb/tb_fetch_queue.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the decoupled instruction fetch front end.
// Slot records carry the fetch PC alongside the returned word.
package riscv_fetch_pkg;

  localparam int XLEN_W = 32;

  localparam logic [XLEN_W-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN_W-1:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [XLEN_W-1:0] PC_STEP      = 32'd4;

  typedef struct packed {
    logic              alloc;
    logic              filled;
    logic [XLEN_W-1:0] pc;
    logic [XLEN_W-1:0] data;
  } fetchSlot_t;

endpackage

// File: rtl/fetch_slot_array.sv
// Storage for in-flight and returned fetches.
// Alloc, fill and free target distinct slots and may all occur in one cycle.
module fetch_slot_array
  import riscv_fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              allocEn,
  input  logic [IW-1:0]     allocIdx,
  input  logic [XLEN_W-1:0] allocPc,
  input  logic              fillEn,
  input  logic [IW-1:0]     fillIdx,
  input  logic [XLEN_W-1:0] fillData,
  input  logic              freeEn,
  input  logic [IW-1:0]     headIdx,
  output fetchSlot_t        headSlot
);

  fetchSlot_t slots [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else begin
      if (allocEn) begin
        slots[allocIdx].alloc  <= 1'b1;
        slots[allocIdx].filled <= 1'b0;
        slots[allocIdx].pc     <= allocPc;
        slots[allocIdx].data   <= '0;
      end
      if (fillEn) begin
        slots[fillIdx].filled <= 1'b1;
        slots[fillIdx].data   <= fillData;
      end
      if (freeEn) begin
        slots[headIdx] <= '0;
      end
    end
  end

  assign headSlot = slots[headIdx];

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch: sequential PC issue, in-order response buffering,
// and redirect flush with dropping of stale in-flight responses.
module fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter  int              DEPTH    = 4,
  parameter  int              XLEN     = 32,
  parameter  logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  localparam int              IW       = $clog2(DEPTH),
  localparam int              CW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pcplus4,
  input  logic            instr_ready,
  output logic [CW-1:0]   inflight
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_P = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] pcQ;
  logic [IW-1:0]   allocPtr;
  logic [IW-1:0]   fillPtr;
  logic [IW-1:0]   headPtr;
  logic [CW-1:0]   occCnt;
  logic [CW-1:0]   unfilledCnt;
  logic [CW-1:0]   dropCnt;
  logic [CW:0]     pendSum;
  logic [CW:0]     redirDrop;

  fetchSlot_t headSlot;

  logic reqFire;
  logic rspDrop;
  logic rspFill;
  logic rspAny;
  logic headValid;
  logic deqFire;
  logic unusedRedirLo;

  // Every request the memory still owes us, stale or live.
  assign pendSum = {1'b0, dropCnt} + {1'b0, unfilledCnt};

  assign imem_req_valid = !rst && !redirect_valid &&
                          (occCnt < DEPTH_C) &&
                          (pendSum < DEPTH_P);
  assign imem_req_addr  = pcQ;
  assign reqFire        = imem_req_valid && imem_req_ready;

  assign rspDrop = imem_rsp_valid && (dropCnt != '0);
  assign rspFill = imem_rsp_valid && (dropCnt == '0) &&
                   (unfilledCnt != '0);
  assign rspAny  = imem_rsp_valid && (pendSum != '0);

  // A response arriving with the redirect is already spent.
  assign redirDrop = pendSum - (CW + 1)'(rspAny);

  assign headValid = !rst && headSlot.alloc && headSlot.filled;
  assign deqFire   = headValid && instr_ready;

  assign instr_valid   = headValid;
  assign instr_data    = headValid ? headSlot.data : '0;
  assign instr_pc      = headValid ? headSlot.pc : '0;
  assign instr_pcplus4 = headValid ? headSlot.pc + PC_STEP : '0;

  assign inflight = pendSum[CW-1:0];

  assign unusedRedirLo = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      pcQ         <= RESET_PC;
      allocPtr    <= '0;
      fillPtr     <= '0;
      headPtr     <= '0;
      occCnt      <= '0;
      unfilledCnt <= '0;
      dropCnt     <= '0;
    end else if (redirect_valid) begin
      pcQ         <= {redirect_pc[XLEN-1:2], 2'b00};
      allocPtr    <= '0;
      fillPtr     <= '0;
      headPtr     <= '0;
      occCnt      <= '0;
      unfilledCnt <= '0;
      dropCnt     <= redirDrop[CW-1:0];
    end else begin
      if (reqFire) begin
        allocPtr <= allocPtr + IW'(1);
        pcQ      <= pcQ + PC_STEP;
      end
      if (rspDrop) begin
        dropCnt <= dropCnt - CW'(1);
      end
      if (rspFill) begin
        fillPtr <= fillPtr + IW'(1);
      end
      if (deqFire) begin
        headPtr <= headPtr + IW'(1);
      end
      occCnt      <= occCnt + CW'(reqFire) - CW'(deqFire);
      unfilledCnt <= unfilledCnt + CW'(reqFire) - CW'(rspFill);
    end
  end

  fetch_slot_array #(
    .DEPTH(DEPTH)
  ) u_slots (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .allocEn  (reqFire),
    .allocIdx (allocPtr),
    .allocPc  (pcQ),
    .fillEn   (rspFill),
    .fillIdx  (fillPtr),
    .fillData (imem_rsp_data),
    .freeEn   (deqFire),
    .headIdx  (headPtr),
    .headSlot (headSlot)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic,
// scored against a queue-based model of fetch requests and results.
module tb_fetch_queue;
  import riscv_fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready = 1'b1;
  logic            imem_rsp_valid = 1'b0;
  logic [XLEN-1:0] imem_rsp_data = '0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            instr_valid;
  logic [XLEN-1:0] instr_data;
  logic [XLEN-1:0] instr_pc;
  logic [XLEN-1:0] instr_pcplus4;
  logic            instr_ready = 1'b1;
  logic [CW-1:0]   inflight;

  always #5 clk = ~clk;

  fetch_queue #(
    .DEPTH(DEPTH), .XLEN(XLEN), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_data(instr_data),
    .instr_pc(instr_pc),
    .instr_pcplus4(instr_pcplus4),
    .instr_ready(instr_ready),
    .inflight(inflight)
  );

  int total = 0;
  int bad = 0;
  int memLat = 1;
  int cyc = 0;
  bit synced = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } outEnt_t;

  memReq_t     memQ[$];
  outEnt_t     mOut[$];
  logic [31:0] mReady[$];
  logic [31:0] mPc = 32'h0;
  logic [31:0] acceptLog[$];

  function automatic logic [31:0] memFn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // One clock: score outputs, step the memory and the model.
  task automatic tick();
    int          live;
    bit          eReqV, eIV, cRst, cRedir, cAcc, cDutAcc, cDeq, cRsp;
    logic [31:0] ePc, eData, ePc4, cRpc, cAddr;
    outEnt_t     e;
    #1;
    live = 0;
    foreach (mOut[i]) if (!mOut[i].stale) live++;
    eReqV = !rst && !redirect_valid && (mOut.size() < DEPTH) &&
            (live + mReady.size() < DEPTH);
    eIV   = !rst && (mReady.size() > 0);
    ePc   = eIV ? mReady[0] : 32'h0;
    eData = eIV ? memFn(ePc) : 32'h0;
    ePc4  = eIV ? ePc + 32'd4 : 32'h0;
    total++;
    if (imem_req_valid !== eReqV) begin
      bad++;
      $display("FAIL req_valid cyc=%0d got=%0b want=%0b",
               cyc, imem_req_valid, eReqV);
    end
    if (synced && eReqV) begin
      total++;
      if (imem_req_addr !== mPc) begin
        bad++;
        $display("FAIL req_addr cyc=%0d got=%h want=%h",
                 cyc, imem_req_addr, mPc);
      end
    end
    total++;
    if (instr_valid !== eIV) begin
      bad++;
      $display("FAIL instr_valid cyc=%0d got=%0b want=%0b",
               cyc, instr_valid, eIV);
    end
    total++;
    if (instr_pc !== ePc) begin
      bad++;
      $display("FAIL instr_pc cyc=%0d got=%h want=%h",
               cyc, instr_pc, ePc);
    end
    total++;
    if (instr_data !== eData) begin
      bad++;
      $display("FAIL instr_data cyc=%0d got=%h want=%h",
               cyc, instr_data, eData);
    end
    total++;
    if (instr_pcplus4 !== ePc4) begin
      bad++;
      $display("FAIL pcplus4 cyc=%0d got=%h want=%h",
               cyc, instr_pcplus4, ePc4);
    end
    if (synced) begin
      total++;
      if (inflight !== CW'(mOut.size())) begin
        bad++;
        $display("FAIL inflight cyc=%0d got=%0d want=%0d",
                 cyc, inflight, mOut.size());
      end
    end
    cRst    = rst;
    cRedir  = redirect_valid;
    cRpc    = redirect_pc;
    cAcc    = eReqV && imem_req_ready;
    cDutAcc = imem_req_valid && imem_req_ready;
    cAddr   = imem_req_addr;
    cDeq    = eIV && instr_ready;
    cRsp    = imem_rsp_valid;
    @(posedge clk);
    #1;
    cyc++;
    if (cRst) begin
      memQ.delete();
    end else if (cDutAcc) begin
      memQ.push_back('{cAddr, cyc + memLat - 1});
      acceptLog.push_back(cAddr);
    end
    if (memQ.size() > 0 && memQ[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memFn(memQ[0].addr);
      void'(memQ.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    if (cRst) begin
      mOut.delete();
      mReady.delete();
      mPc = 32'h0;
      synced = 1;
    end else if (cRedir) begin
      if (cRsp && mOut.size() > 0) void'(mOut.pop_front());
      foreach (mOut[i]) mOut[i].stale = 1;
      mReady.delete();
      mPc = cRpc & ~32'h3;
    end else begin
      if (cDeq) void'(mReady.pop_front());
      if (cRsp && mOut.size() > 0) begin
        e = mOut.pop_front();
        if (!e.stale) mReady.push_back(e.pc);
      end
      if (cAcc) begin
        mOut.push_back('{mPc, 1'b0});
        mPc = mPc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int lat);
    rst = 1'b1;
    redirect_valid = 1'b0;
    memLat = lat;
    tick();
    rst = 1'b0;
    acceptLog.delete();
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    int n = 0;
    ok = 0;
    #1;
    while (n < budget && !instr_valid) begin
      tick();
      #1;
      n++;
    end
    ok = instr_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;
    tick();
    tick();
    #1;
    total++;
    if (imem_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_req_valid got=%0b want=0", imem_req_valid);
    end
    total++;
    if (instr_valid !== 1'b0 || instr_data !== '0) begin
      bad++;
      $display("FAIL rst_instr got=%0b/%h want=0/0",
               instr_valid, instr_data);
    end
    total++;
    if (inflight !== '0) begin
      bad++;
      $display("FAIL rst_inflight got=%0d want=0", inflight);
    end
  endtask

  task automatic test_stream();
    logic [31:0] want;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      want = 32'(k - 2) * 32'd4;
      total++;
      if (k < 2 && instr_valid !== 1'b0) begin
        bad++;
        $display("FAIL stream_early k=%0d got=%0b want=0", k, instr_valid);
      end else if (k >= 2 && (instr_valid !== 1'b1 || instr_pc !== want ||
                              instr_pcplus4 !== want + 32'd4)) begin
        bad++;
        $display("FAIL stream_pc k=%0d got=%0b/%h want=1/%h",
                 k, instr_valid, instr_pc, want);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    rst = 1'b1;
    instr_ready = 1'b0;
    do_reset(1);
    repeat (10) tick();
    #1;
    total++;
    if (acceptLog.size() != DEPTH) begin
      bad++;
      $display("FAIL bp_count got=%0d want=%0d", acceptLog.size(), DEPTH);
    end
    foreach (acceptLog[i]) begin
      total++;
      if (acceptLog[i] !== 32'(i) * 32'd4) begin
        bad++;
        $display("FAIL bp_addr i=%0d got=%h want=%h",
                 i, acceptLog[i], 32'(i) * 32'd4);
      end
    end
    total++;
    if (imem_req_valid !== 1'b0 || instr_pc !== 32'h0) begin
      bad++;
      $display("FAIL bp_full got=%0b/%h want=0/0", imem_req_valid, instr_pc);
    end
    instr_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(k) * 32'd4) begin
        bad++;
        $display("FAIL bp_drain k=%0d got=%0b/%h want=1/%h",
                 k, instr_valid, instr_pc, 32'(k) * 32'd4);
      end
      tick();
    end
  endtask

  task automatic test_redirect_drop();
    int n = 0;
    bit ok;
    instr_ready = 1'b1;
    imem_req_ready = 1'b1;
    do_reset(3);
    #1;
    while (n < 20 && inflight !== CW'(3)) begin
      tick();
      #1;
      n++;
    end
    total++;
    if (inflight !== CW'(3)) begin
      bad++;
      $display("FAIL drop_setup got=%0d want=3", inflight);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    #1;
    total++;
    if (inflight !== CW'(2)) begin
      bad++;
      $display("FAIL drop_inflight got=%0d want=2", inflight);
    end
    wait_valid(30, ok);
    total++;
    if (!ok || instr_pc !== 32'h100 || instr_data !== memFn(32'h100)) begin
      bad++;
      $display("FAIL drop_first got=%0b/%h/%h want=1/100/%h",
               ok, instr_pc, instr_data, memFn(32'h100));
    end
  endtask

  task automatic test_double_redirect();
    bit ok;
    instr_ready = 1'b1;
    do_reset(3);
    repeat (6) tick();
    acceptLog.delete();
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0;
    wait_valid(30, ok);
    total++;
    if (!ok || instr_pc !== 32'h300) begin
      bad++;
      $display("FAIL dbl_first got=%0b/%h want=1/300", ok, instr_pc);
    end
    total++;
    if (acceptLog.size() == 0 || acceptLog[0] !== 32'h300) begin
      bad++;
      $display("FAIL dbl_issue got=%0d entries want first=300",
               acceptLog.size());
    end
  endtask

  task automatic test_misaligned();
    bit ok;
    do_reset(1);
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
        bad++;
        $display("FAIL hold k=%0d got=%0b/%h want=1/100",
                 k, imem_req_valid, imem_req_addr);
      end
      tick();
    end
    imem_req_ready = 1'b1;
    wait_valid(20, ok);
    total++;
    if (!ok || instr_pc !== 32'h100) begin
      bad++;
      $display("FAIL align_first got=%0b/%h want=1/100", ok, instr_pc);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    instr_ready = 1'b0;
    do_reset(1);
    while (n < 20 && mReady.size() != 2) begin
      tick();
      n++;
    end
    #1;
    total++;
    if (instr_valid !== 1'b1 || mReady.size() != 2) begin
      bad++;
      $display("FAIL mid_setup got=%0b want=1", instr_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (instr_valid !== 1'b0 || inflight !== '0) begin
      bad++;
      $display("FAIL mid_clear got=%0b/%0d want=0/0", instr_valid, inflight);
    end
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      bad++;
      $display("FAIL mid_restart got=%0b/%h want=1/0",
               imem_req_valid, imem_req_addr);
    end
    tick();
    instr_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_random();
    do_reset(2);
    for (int k = 0; k < 3000; k++) begin
      if (k % 500 == 0) memLat = 1 + int'($urandom_range(0, 3));
      imem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : $urandom;
      tick();
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_double_redirect();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
